// File: rtl/sipo_frame_rx_if.sv
// sipo_frame_rx_if
//   Bundles the serial input and the parallel valid/ready output of the
//   SIPO frame receiver.
//   Signals:
//     s_in      serial line (driven by the transmitter side)
//     p_out     received word
//     p_valid   word available
//     p_ready   consumer accepts p_out when p_valid & p_ready
//     busy      frame reception in progress
//     frame_err one-cycle pulse on a bad stop bit
//     overrun   one-cycle pulse when a good frame is dropped (buffer full)
//   Modports:
//     master  line driver / consumer side (drives s_in, p_ready)
//     slave   receiver side (drives p_out, p_valid, busy, frame_err, overrun)
interface sipo_frame_rx_if #(
  parameter int WIDTH = 4
);
  logic             s_in;
  logic [WIDTH-1:0] p_out;
  logic             p_valid;
  logic             p_ready;
  logic             busy;
  logic             frame_err;
  logic             overrun;

  modport master (
    output s_in,
    output p_ready,
    input  p_out,
    input  p_valid,
    input  busy,
    input  frame_err,
    input  overrun
  );

  modport slave (
    input  s_in,
    input  p_ready,
    output p_out,
    output p_valid,
    output busy,
    output frame_err,
    output overrun
  );
endinterface

// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx
//   Serial-in, parallel-out frame receiver. Frame on s_in: idle 0, start
//   bit 1, WIDTH data bits MSB first, stop bit 0. Good words land in a
//   single-entry output buffer with a valid/ready handshake.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  sipo_frame_rx_if.slave (s_in, p_ready in; p_out, p_valid,
//          busy, frame_err, overrun out -- all outputs registered)
module sipo_frame_rx #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  sipo_frame_rx_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] shreg;
  logic             shift_en;
  logic             cnt_clr;
  logic             stop_smp;

  // Next-state decode and per-state control strobes.
  always_comb begin
    state_d  = state_q;
    shift_en = 1'b0;
    cnt_clr  = 1'b0;
    stop_smp = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.s_in) begin
          state_d = SHIFT;
          cnt_clr = 1'b1;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = STOP;
        end
      end
      STOP: begin
        // The stop bit is consumed here unconditionally, so a bad (1) stop
        // bit can never be mistaken for the next start bit.
        stop_smp = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg   <= '0;
    end else begin
      state_q <= state_d;
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (shift_en) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (shift_en) begin
        shreg <= {shreg[WIDTH-2:0], bus.s_in};
      end
    end
  end

  // Output buffer and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.p_out     <= '0;
      bus.p_valid   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      bus.busy      <= (state_d != IDLE);
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
      if (bus.p_valid && bus.p_ready) begin
        bus.p_valid <= 1'b0;
      end
      if (stop_smp) begin
        if (bus.s_in) begin
          bus.frame_err <= 1'b1;
        end else if (!bus.p_valid || bus.p_ready) begin
          // Empty buffer, or the old word is consumed on this same edge.
          bus.p_out   <= shreg;
          bus.p_valid <= 1'b1;
        end else begin
          bus.overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sipo_frame_rx.sv
module tb_sipo_frame_rx;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sipo_frame_rx_if #(.WIDTH(W)) bus ();

  sipo_frame_rx #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: single-entry buffer plus expected pulses.
  bit           mv;
  logic [W-1:0] md;
  bit           me;
  bit           mo;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply one line bit and ready value for one clock edge, predict the
  // outcome of that edge from the frame rules, then check after the edge.
  task automatic step(input logic s, input logic r, input bit stop_edge,
                      input logic [W-1:0] w, input bit exp_busy, input string tag);
    bit consume;
    bit good;
    bus.s_in    = s;
    bus.p_ready = r;
    consume = mv && r;
    good    = stop_edge && !s;
    me      = stop_edge && s;
    mo      = good && mv && !r;
    if (good && (!mv || r)) begin
      mv = 1'b1;
      md = w;
    end else if (consume) begin
      mv = 1'b0;
    end
    @(posedge clk);
    #1;
    chk({tag, ".busy"},      32'(bus.busy),      32'(exp_busy));
    chk({tag, ".p_valid"},   32'(bus.p_valid),   32'(mv));
    chk({tag, ".frame_err"}, 32'(bus.frame_err), 32'(me));
    chk({tag, ".overrun"},   32'(bus.overrun),   32'(mo));
    if (mv) chk({tag, ".p_out"}, 32'(bus.p_out), 32'(md));
  endtask

  function automatic logic pick(input bit rnd, input logic fixed);
    if (rnd) return 1'($urandom_range(0, 1));
    return fixed;
  endfunction

  task automatic send_frame(input logic [W-1:0] d, input logic stopb,
                            input logic rb, input logic rs, input bit rnd,
                            input string tag);
    step(1'b1, pick(rnd, rb), 1'b0, d, 1'b1, tag);
    for (int i = W - 1; i >= 0; i--) begin
      step(d[i], pick(rnd, rb), 1'b0, d, 1'b1, tag);
    end
    step(stopb, pick(rnd, rs), 1'b1, d, 1'b0, tag);
  endtask

  task automatic idle(input logic r, input string tag);
    step(1'b0, r, 1'b0, '0, 1'b0, tag);
  endtask

  task automatic do_reset(input int n, input logic s, input logic r, input string tag);
    rst         = 1'b1;
    bus.s_in    = s;
    bus.p_ready = r;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.s_in    = 1'b0;
    bus.p_ready = 1'b0;
    mv = 1'b0;
    me = 1'b0;
    mo = 1'b0;
    chk({tag, ".busy"},      32'(bus.busy),      0);
    chk({tag, ".p_valid"},   32'(bus.p_valid),   0);
    chk({tag, ".frame_err"}, 32'(bus.frame_err), 0);
    chk({tag, ".overrun"},   32'(bus.overrun),   0);
    chk({tag, ".p_out"},     32'(bus.p_out),     0);
  endtask

  initial begin
    rst         = 1'b1;
    bus.s_in    = 1'b0;
    bus.p_ready = 1'b0;
    mv = 1'b0; md = '0; me = 1'b0; mo = 1'b0;

    // Reset, then a basic all-ones frame held until accepted.
    do_reset(2, 1'b0, 1'b0, "rst0");
    send_frame(4'hF, 1'b0, 1'b0, 1'b0, 1'b0, "basicF");
    idle(1'b0, "holdF");
    idle(1'b0, "holdF");
    idle(1'b1, "takeF");
    idle(1'b0, "afterF");

    // MSB-first ordering.
    send_frame(4'hE, 1'b0, 1'b0, 1'b0, 1'b0, "msbE");
    idle(1'b1, "takeE");
    send_frame(4'h1, 1'b0, 1'b0, 1'b0, 1'b0, "msb1");
    idle(1'b1, "take1");

    // Framing error: stop bit 1 must not start a new frame.
    send_frame(4'hA, 1'b1, 1'b0, 1'b0, 1'b0, "ferrA");
    idle(1'b0, "ferr_idle");
    idle(1'b0, "ferr_idle2");

    // Overrun: second frame dropped while buffer full and not ready.
    send_frame(4'h5, 1'b0, 1'b0, 1'b0, 1'b0, "ovr5");
    send_frame(4'h3, 1'b0, 1'b0, 1'b0, 1'b0, "ovr3");
    idle(1'b1, "ovr_take");
    // Same, but ready on the second stop edge: replace in place.
    send_frame(4'h5, 1'b0, 1'b0, 1'b0, 1'b0, "rep5");
    send_frame(4'h3, 1'b0, 1'b0, 1'b1, 1'b0, "rep3");
    idle(1'b1, "rep_take");

    // Back-to-back with ready held high.
    send_frame(4'hC, 1'b0, 1'b1, 1'b1, 1'b0, "b2bC");
    send_frame(4'h9, 1'b0, 1'b1, 1'b1, 1'b0, "b2b9");
    idle(1'b1, "b2b_idle");

    // Reset mid-frame with a word buffered; reset wins over ready and s_in.
    send_frame(4'h6, 1'b0, 1'b0, 1'b0, 1'b0, "pre6");
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, "mid_start");
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, "mid_d3");
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, "mid_d2");
    do_reset(1, 1'b1, 1'b1, "rst_mid");
    send_frame(4'h7, 1'b0, 1'b0, 1'b0, 1'b0, "post7");
    idle(1'b1, "take7");

    // Randomized frames, gaps, stop errors and ready patterns.
    for (int k = 0; k < 150; k++) begin
      logic [W-1:0] d;
      logic         sb;
      int           gap;
      d   = W'($urandom_range(0, (1 << W) - 1));
      sb  = ($urandom_range(0, 7) == 0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle(1'($urandom_range(0, 1)), "rnd_gap");
      send_frame(d, sb, 1'b0, 1'b0, 1'b1, "rnd");
    end
    idle(1'b1, "end_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
